// File: rtl/inv_key_expansion_if.sv
// Key-in / round-key-out handshake bundle for the inverse AES-128 key schedule.
interface inv_key_expansion_if;
    logic         i_tx_en;
    logic [127:0] i_key;
    logic         o_ready;
    logic         o_tx_en;
    logic         i_rdy;
    logic [127:0] o_round_key;
    logic [3:0]   o_round_idx;
    logic         o_last;

    modport slave (
        input  i_tx_en, i_key, i_rdy,
        output o_ready, o_tx_en, o_round_key, o_round_idx, o_last
    );

    modport master (
        output i_tx_en, i_key, i_rdy,
        input  o_ready, o_tx_en, o_round_key, o_round_idx, o_last
    );
endinterface

// File: rtl/inv_key_expansion.sv
// Iterative AES-128 inverse key schedule: takes round key NR and emits
// round keys NR down to 0, one per completed output beat.
module inv_key_expansion #(
    parameter int unsigned NR = 10
) (
    input logic              clock,
    input logic              reset,
    inv_key_expansion_if.slave bus
);

    localparam int unsigned KEY_W = 128;
    localparam int unsigned IDX_W = 4;

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE, EMIT} state_t;

    state_t             state;
    logic [KEY_W-1:0]   key_q;
    logic [IDX_W-1:0]   idx_q;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] g_word;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [IDX_W-1:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One step back through the key schedule: round idx_q key -> round idx_q-1 key.
    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;
    assign g_word = {sbox(p3[23:16]) ^ rcon(idx_q), sbox(p3[15:8]),
                     sbox(p3[7:0]), sbox(p3[31:24])};
    assign p0 = w0 ^ g_word;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            key_q <= '0;
            idx_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_tx_en) begin
                        key_q <= bus.i_key;
                        idx_q <= IDX_W'(NR);
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.i_rdy) begin
                        if (idx_q == '0) begin
                            state <= IDLE;
                        end else begin
                            key_q <= {p0, p1, p2, p3};
                            idx_q <= idx_q - IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags decode straight from the state and round index registers.
    assign bus.o_ready     = (state == IDLE);
    assign bus.o_tx_en     = (state == EMIT);
    assign bus.o_round_key = key_q;
    assign bus.o_round_idx = idx_q;
    assign bus.o_last      = (state == EMIT) && (idx_q == '0);

endmodule

// File: tb/tb_inv_key_expansion.sv
// Self-checking bench for inv_key_expansion against a forward AES-128 key
// expansion model built from GF(2^8) arithmetic.
module tb_inv_key_expansion;

    localparam int unsigned NR = 10;

    logic clock;
    logic reset;
    inv_key_expansion_if bus ();

    inv_key_expansion #(.NR(NR)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [7:0]   sbox_t [256];
    logic [7:0]   rcon_t [11];
    logic [127:0] rk     [11];

    logic [127:0] q_key [$];
    logic [3:0]   q_idx [$];
    logic         q_last [$];
    int  stall_err, ready_err, done_cyc;
    bit  first_ok, ready_after, timed_out;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_t[x] = s;
        end
        rcon_t[0] = 8'h00;
        rcon_t[1] = 8'h01;
        for (int i = 2; i < 11; i++) rcon_t[i] = gmul(rcon_t[i-1], 8'h02);
    endtask

    // Forward expansion of a cipher key into all 11 round keys.
    task automatic expand(input logic [127:0] ck);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = ck[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
                    ^ {rcon_t[i/4], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Offer a key, then collect beats with random backpressure; optionally spam i_tx_en.
    task automatic run_key(input logic [127:0] key, input int low_pct, input bit inject);
        int guard;
        logic [127:0] hold_k;
        logic [3:0]   hold_i;
        logic         hold_l;
        bit held;
        q_key.delete(); q_idx.delete(); q_last.delete();
        stall_err = 0; ready_err = 0; done_cyc = 0; timed_out = 0; held = 0;
        hold_k = '0; hold_i = '0; hold_l = 1'b0;
        guard = 0;
        while (!bus.o_ready && guard < 50) begin @(negedge clock); guard++; end
        bus.i_key = key; bus.i_tx_en = 1'b1; bus.i_rdy = 1'b1;
        @(negedge clock);
        bus.i_tx_en = 1'b0;
        first_ok = bus.o_tx_en && (bus.o_round_idx == 4'(NR)) && (bus.o_round_key === key);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (bus.o_ready || !bus.o_tx_en) ready_err++;
            if (held && (bus.o_round_key !== hold_k || bus.o_round_idx !== hold_i ||
                         bus.o_last !== hold_l)) stall_err++;
            bus.i_rdy = ($urandom_range(0, 99) >= low_pct);
            if (inject) begin
                bus.i_tx_en = 1'($urandom_range(0, 1));
                bus.i_key = {$urandom, $urandom, $urandom, $urandom};
            end
            if (bus.i_rdy) begin
                q_key.push_back(bus.o_round_key);
                q_idx.push_back(bus.o_round_idx);
                q_last.push_back(bus.o_last);
                held = 0;
                if (bus.o_round_idx == 4'd0) begin
                    done_cyc = cyc;
                    bus.i_tx_en = 1'b0;
                end
            end else begin
                held = 1; hold_k = bus.o_round_key; hold_i = bus.o_round_idx; hold_l = bus.o_last;
            end
            @(negedge clock);
            if (done_cyc != 0) break;
        end
        ready_after = bus.o_ready;
        bus.i_rdy = 1'b1; bus.i_tx_en = 1'b0;
        if (done_cyc == 0) timed_out = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.i_tx_en = 1'b0; bus.i_key = '0; bus.i_rdy = 1'b0;
        @(negedge clock);
        tests++; if (bus.o_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", bus.o_ready); end
        tests++; if (bus.o_tx_en !== 1'b0) begin fails++; $display("FAIL reset_tx_en got %b want 0", bus.o_tx_en); end
        tests++; if (bus.o_round_key !== 128'h0) begin fails++; $display("FAIL reset_key got %h want 0", bus.o_round_key); end
        tests++; if (bus.o_round_idx !== 4'd0) begin fails++; $display("FAIL reset_idx got %0d want 0", bus.o_round_idx); end
        tests++; if (bus.o_last !== 1'b0) begin fails++; $display("FAIL reset_last got %b want 0", bus.o_last); end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_fips();
        logic [127:0] exp_k [4];
        int           exp_i [4];
        int           k;
        exp_k[0] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6; exp_i[0] = 10;
        exp_k[1] = 128'hac7766f319fadc2128d12941575c006e; exp_i[1] = 9;
        exp_k[2] = 128'ha0fafe1788542cb123a339392a6c7605; exp_i[2] = 1;
        exp_k[3] = 128'h2b7e151628aed2a6abf7158809cf4f3c; exp_i[3] = 0;
        run_key(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0, 0);
        tests++; if (!first_ok) begin fails++; $display("FAIL fips_latency got tx=%b idx=%0d want tx=1 idx=10", bus.o_tx_en, bus.o_round_idx); end
        tests++; if (q_key.size() != 11) begin fails++; $display("FAIL fips_beats got %0d want 11", q_key.size()); end
        tests++; if (done_cyc != 11) begin fails++; $display("FAIL fips_cycles got %0d want 11", done_cyc); end
        tests++; if (ready_after !== 1'b1) begin fails++; $display("FAIL fips_ready_after got %b want 1", ready_after); end
        for (int j = 0; j < 4; j++) begin
            k = NR - exp_i[j];
            if (k < q_key.size()) begin
                tests++;
                if (q_key[k] !== exp_k[j] || q_idx[k] !== 4'(exp_i[j]))
                begin fails++; $display("FAIL fips_beat%0d got %h idx %0d want %h idx %0d", exp_i[j], q_key[k], q_idx[k], exp_k[j], exp_i[j]); end
            end
        end
        if (q_last.size() == 11) begin
            tests++; if (q_last[10] !== 1'b1 || q_last[9] !== 1'b0)
            begin fails++; $display("FAIL fips_last got %b/%b want 0/1", q_last[9], q_last[10]); end
        end
    endtask

    // Every collected beat against the model's round keys.
    task automatic check_seq(input string name);
        tests++;
        if (q_key.size() != 11) begin fails++; $display("FAIL %s_count got %0d want 11", name, q_key.size()); end
        for (int k = 0; k < q_key.size() && k < 11; k++) begin
            tests++;
            if (q_key[k] !== rk[NR-k] || q_idx[k] !== 4'(NR-k) || q_last[k] !== (k == NR))
            begin fails++; $display("FAIL %s_beat%0d got %h idx %0d last %b want %h idx %0d", name, k, q_key[k], q_idx[k], q_last[k], rk[NR-k], NR-k); end
        end
    endtask

    task automatic test_zero_key();
        expand(128'h0);
        run_key(128'hb4ef5bcb3e92e21123e951cf6f8f188e, 0, 0);
        check_seq("zero");
        tests++; if (q_key.size() == 11 && q_key[10] !== 128'h0)
        begin fails++; $display("FAIL zero_final got %h want 0", q_key[10]); end
    endtask

    task automatic test_random_keys();
        logic [127:0] ck;
        for (int n = 0; n < 4; n++) begin
            ck = {$urandom, $urandom, $urandom, $urandom};
            expand(ck);
            run_key(rk[NR], 0, 0);
            check_seq("random");
            tests++; if (done_cyc != 11 || ready_err != 0)
            begin fails++; $display("FAIL random_timing got cyc %0d rdyerr %0d want 11/0", done_cyc, ready_err); end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] ck;
        for (int n = 0; n < 2; n++) begin
            ck = {$urandom, $urandom, $urandom, $urandom};
            expand(ck);
            run_key(rk[NR], 40, 0);
            check_seq("stall");
            tests++; if (stall_err != 0 || timed_out)
            begin fails++; $display("FAIL stall_hold got %0d changes timeout %b want 0/0", stall_err, timed_out); end
        end
    endtask

    task automatic test_busy_drop();
        logic [127:0] ck;
        ck = {$urandom, $urandom, $urandom, $urandom};
        expand(ck);
        run_key(rk[NR], 20, 1);
        check_seq("busy");
        tests++; if (ready_err != 0) begin fails++; $display("FAIL busy_ready got %0d bad cycles want 0", ready_err); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] ck;
        int guard;
        ck = {$urandom, $urandom, $urandom, $urandom};
        expand(ck);
        bus.i_key = rk[NR]; bus.i_tx_en = 1'b1; bus.i_rdy = 1'b1;
        @(negedge clock);
        bus.i_tx_en = 1'b0;
        guard = 0;
        while (bus.o_round_idx != 4'd6 && guard < 20) begin @(negedge clock); guard++; end
        tests++; if (bus.o_round_key !== rk[6] || bus.o_tx_en !== 1'b1)
        begin fails++; $display("FAIL rstmid_pre got %h tx %b want %h tx 1", bus.o_round_key, bus.o_tx_en, rk[6]); end
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        tests++;
        if (bus.o_ready !== 1'b1 || bus.o_tx_en !== 1'b0 || bus.o_round_key !== 128'h0 ||
            bus.o_round_idx !== 4'd0 || bus.o_last !== 1'b0)
        begin fails++; $display("FAIL rstmid_clear got rdy %b tx %b key %h idx %0d last %b want 1 0 0 0 0", bus.o_ready, bus.o_tx_en, bus.o_round_key, bus.o_round_idx, bus.o_last); end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        ck = {$urandom, $urandom, $urandom, $urandom};
        expand(ck);
        run_key(rk[NR], 0, 0);
        tests++; if (!first_ok) begin fails++; $display("FAIL rstmid_restart got first beat bad want idx 10 key %h", rk[NR]); end
        check_seq("restart");
    endtask

    task automatic test_back_to_back();
        logic [127:0] rka [11];
        logic [127:0] rkb [11];
        logic [127:0] ka, kb;
        int cyc_end;
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        expand(ka); rka = rk;
        expand(kb); rkb = rk;
        q_key.delete(); q_idx.delete(); q_last.delete();
        cyc_end = 0;
        bus.i_key = rka[NR]; bus.i_tx_en = 1'b1; bus.i_rdy = 1'b1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clock);
            if (bus.o_tx_en) begin
                q_key.push_back(bus.o_round_key);
                q_idx.push_back(bus.o_round_idx);
            end
            if (cyc == 1) bus.i_key = rkb[NR];
            if (q_key.size() >= 12) bus.i_tx_en = 1'b0;
            if (bus.o_ready && q_key.size() >= 22) begin cyc_end = cyc; break; end
        end
        bus.i_tx_en = 1'b0;
        tests++; if (q_key.size() != 22) begin fails++; $display("FAIL b2b_beats got %0d want 22", q_key.size()); end
        tests++; if (cyc_end != 24) begin fails++; $display("FAIL b2b_cycles got %0d want 24", cyc_end); end
        for (int k = 0; k < q_key.size() && k < 22; k++) begin
            tests++;
            if (q_key[k] !== ((k < 11) ? rka[NR-k] : rkb[NR-(k-11)]) || q_idx[k] !== 4'(NR - (k % 11)))
            begin fails++; $display("FAIL b2b_beat%0d got %h idx %0d", k, q_key[k], q_idx[k]); end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.i_tx_en = 1'b0; bus.i_key = '0; bus.i_rdy = 1'b0;
        build_tables();
        test_reset();
        test_fips();
        test_zero_key();
        test_random_keys();
        test_backpressure();
        test_busy_drop();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
